edge_event_arbiter: RTL

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

---
 rtl/edge_evt_pkg.sv | 17 +
 rtl/edge_sync_det.sv | 30 +++
 rtl/edge_event_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/edge_evt_pkg.sv
// Shared constants, event-type encoding and channel-index width helper
// used by the edge event arbiter and its per-channel detector.
package edge_evt_pkg;

  localparam int DEF_NCH = 4;
  localparam int DEF_TSW = 16;

  typedef enum logic {
    EVT_FALL = 1'b0,
    EVT_RISE = 1'b1
  } evt_type_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_sync_det.sv
// One channel: two-flop synchronizer, history flop and rise/fall detection.
// Detection outputs are one-cycle pulses derived from registered state.
module edge_sync_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= sig_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~hist_q;
  assign fall_o = ~sync_q & hist_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge capture with rise/fall pending bits, round-robin arbitration
// and a registered valid/ready output stage. EDGE_EVENT_ARBITER_TIMESTAMP_EN adds evt_ts.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int TSW = DEF_TSW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           sig_in,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(NCH)-1:0]   evt_ch,
  output logic                     evt_rise,
  output logic [NCH-1:0]           ovf,
`ifdef EDGE_EVENT_ARBITER_TIMESTAMP_EN
  output logic [TSW-1:0]           evt_ts,
`endif
  input  logic                     ovf_clr
);

  localparam int CHW = ch_w(NCH);

  logic [NCH-1:0] rise_det;
  logic [NCH-1:0] fall_det;

  logic [NCH-1:0] rp_q, rp_d;
  logic [NCH-1:0] fp_q, fp_d;
  logic [NCH-1:0] rfirst_q, rfirst_d;
  logic [NCH-1:0] ovf_q, ovf_d;
  logic [CHW-1:0] ptr_q, ptr_d;

  logic           vld_q, vld_d;
  logic [CHW-1:0] ch_q, ch_d;
  evt_type_e      type_q, type_d;

  logic           gnt_any;
  logic [CHW-1:0] gnt_ch;
  logic           gnt_rise;
  logic           load;
  logic           do_gnt;
  logic [NCH-1:0] gnt_oh;
  logic [NCH-1:0] gnt_r_vec, gnt_f_vec;
  logic [NCH-1:0] r_keep, f_keep;
  logic [NCH-1:0] new_r, new_f;
  int             idx;
  logic [CHW-1:0] sel;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    edge_sync_det u_det (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (sig_in[c]),
      .rise_o (rise_det[c]),
      .fall_o (fall_det[c])
    );
  end

  // Round-robin search starting at ptr_q for the first channel with anything pending.
  always_comb begin
    gnt_any = 1'b0;
    gnt_ch  = '0;
    idx     = 0;
    sel     = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      sel = CHW'(idx);
      if (!gnt_any && (rp_q[sel] || fp_q[sel])) begin
        gnt_any = 1'b1;
        gnt_ch  = sel;
      end
    end
  end

  // With both edges pending the order bit decides which one leaves first.
  assign gnt_rise = rp_q[gnt_ch] & (~fp_q[gnt_ch] | rfirst_q[gnt_ch]);
  assign load     = ~vld_q | evt_ready;
  assign do_gnt   = load & gnt_any;
  assign gnt_oh   = {{(NCH-1){1'b0}}, 1'b1} << gnt_ch;

  assign gnt_r_vec = (do_gnt &&  gnt_rise) ? gnt_oh : '0;
  assign gnt_f_vec = (do_gnt && !gnt_rise) ? gnt_oh : '0;

  assign r_keep = rp_q & ~gnt_r_vec;
  assign f_keep = fp_q & ~gnt_f_vec;
  assign new_r  = rise_det & ~r_keep;
  assign new_f  = fall_det & ~f_keep;

  // A fresh edge is dropped only when its bit stays occupied; a same-cycle grant frees it.
  assign rp_d     = r_keep | rise_det;
  assign fp_d     = f_keep | fall_det;
  assign ovf_d    = (ovf_q & {NCH{~ovf_clr}}) | (rise_det & r_keep) | (fall_det & f_keep);
  assign rfirst_d = (rfirst_q & ~(new_r & f_keep)) | (new_f & r_keep);

  always_comb begin
    ptr_d  = ptr_q;
    vld_d  = vld_q;
    ch_d   = ch_q;
    type_d = type_q;
    if (do_gnt) begin
      ptr_d = (gnt_ch == CHW'(NCH - 1)) ? '0 : gnt_ch + CHW'(1);
    end
    if (load) begin
      vld_d = gnt_any;
      if (gnt_any) begin
        ch_d   = gnt_ch;
        type_d = gnt_rise ? EVT_RISE : EVT_FALL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp_q     <= '0;
      fp_q     <= '0;
      rfirst_q <= '0;
      ovf_q    <= '0;
      ptr_q    <= '0;
      vld_q    <= 1'b0;
      ch_q     <= '0;
      type_q   <= EVT_FALL;
    end else begin
      rp_q     <= rp_d;
      fp_q     <= fp_d;
      rfirst_q <= rfirst_d;
      ovf_q    <= ovf_d;
      ptr_q    <= ptr_d;
      vld_q    <= vld_d;
      ch_q     <= ch_d;
      type_q   <= type_d;
    end
  end

  assign evt_valid = vld_q;
  assign evt_ch    = ch_q;
  assign evt_rise  = (type_q == EVT_RISE);
  assign ovf       = ovf_q;

`ifdef EDGE_EVENT_ARBITER_TIMESTAMP_EN
  logic [TSW-1:0] ts_cnt_q;
  logic [TSW-1:0] ts_r_q [NCH];
  logic [TSW-1:0] ts_f_q [NCH];
  logic [TSW-1:0] ts_out_q;

  // Each pending bit remembers the counter value of the cycle it was set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt_q <= '0;
      ts_out_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        ts_r_q[c] <= '0;
        ts_f_q[c] <= '0;
      end
    end else begin
      ts_cnt_q <= ts_cnt_q + TSW'(1);
      for (int c = 0; c < NCH; c++) begin
        if (new_r[c]) ts_r_q[c] <= ts_cnt_q;
        if (new_f[c]) ts_f_q[c] <= ts_cnt_q;
      end
      if (do_gnt) ts_out_q <= gnt_rise ? ts_r_q[gnt_ch] : ts_f_q[gnt_ch];
    end
  end

  assign evt_ts = ts_out_q;
`endif

endmodule
